// File: rtl/regfile_mp_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb_pkg
// Description : Shared constants for the integer register file, decode and
//               the hazard unit: default data width, default register count,
//               index of the hard-wired zero register and the address-width
//               derivation helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_mp_sb_pkg;

    localparam int c_xlen_default  = 32;
    localparam int c_nregs_default = 32;
    localparam int c_zero_reg_idx  = 0;

    // Register address width for a given register count. A single-register
    // file still needs a 1-bit address so that port slices stay non-empty.
    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage : regfile_mp_sb_pkg
`default_nettype wire

// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb_if
// Description : Bus between the pipeline (master) and the register file with
//               scoreboard (slave). Carries read ports, write ports, the
//               issue-time claim and the registered scoreboard vector.
// Ports       : master drives rd_addr, wr_en/wr_addr/wr_data,
//               claim_en/claim_addr; slave drives rd_data, rd_pending,
//               pending_vec.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int NREGS = c_nregs_default,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = addr_width(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic [NREGS-1:0]    pending_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        input  rd_data, rd_pending, pending_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
        output rd_data, rd_pending, pending_vec
    );

endinterface : regfile_mp_sb_if
`default_nettype wire

// File: rtl/regfile_mp_sb_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb_rd_port
// Description : One combinational read port: storage mux, optional
//               write-to-read bypass (highest write port wins), pending-bit
//               lookup with same-cycle writeback masking, zero-register force.
// Ports       : i_addr        read address
//               i_regs        flattened storage, register i at [i*XLEN +: XLEN]
//               i_pending_vec registered scoreboard state
//               i_clr_vec     registers hit by a write this cycle
//               i_wr_en/i_wr_addr/i_wr_data  write ports (bypass source)
//               o_data        read data
//               o_pending     register has an outstanding producer
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb_rd_port
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN     = c_xlen_default,
    parameter int NREGS    = c_nregs_default,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic [addr_width(NREGS)-1:0]     i_addr,
    input  wire logic [NREGS*XLEN-1:0]            i_regs,
    input  wire logic [NREGS-1:0]                 i_pending_vec,
    input  wire logic [NREGS-1:0]                 i_clr_vec,
    input  wire logic [NWR-1:0]                   i_wr_en,
    input  wire logic [NWR*addr_width(NREGS)-1:0] i_wr_addr,
    input  wire logic [NWR*XLEN-1:0]              i_wr_data,
    output logic      [XLEN-1:0]                  o_data,
    output logic                                  o_pending
);
    localparam int AW = addr_width(NREGS);

    always_comb begin
        o_data    = i_regs[int'(i_addr)*XLEN +: XLEN];
        o_pending = i_pending_vec[i_addr];

        if (BYPASS != 0) begin
            // Ascending scan so the highest-index matching port is kept,
            // matching the priority the storage update uses.
            for (int w = 0; w < NWR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == i_addr)) begin
                    o_data = i_wr_data[w*XLEN +: XLEN];
                end
            end
            // A writeback landing this cycle resolves the hazard now; a claim
            // landing this cycle is deliberately not looked at.
            o_pending = i_pending_vec[i_addr] & ~i_clr_vec[i_addr];
        end

        if ((ZERO_REG != 0) && (i_addr == AW'(c_zero_reg_idx))) begin
            o_data    = '0;
            o_pending = 1'b0;
        end
    end

endmodule : regfile_mp_sb_rd_port
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port integer register file with integrated scoreboard.
//               NRD combinational read ports, NWR synchronous write ports
//               (highest port wins on collision), one pending bit per
//               register set by issue claims and cleared by writeback.
// Ports       : clk    rising-edge clock
//               reset  synchronous active-high reset
//               bus    regfile_mp_sb_if slave modport (read/write/claim
//                      ports and pending_vec)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int XLEN     = c_xlen_default,
    parameter int NREGS    = c_nregs_default,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    regfile_mp_sb_if.slave  bus
);
    localparam int AW = addr_width(NREGS);

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_pending;

    logic [XLEN-1:0]       w_wr_val [NREGS];
    logic [NREGS-1:0]      w_wr_hit;
    logic [NREGS-1:0]      w_claim_hit;
    logic [NREGS*XLEN-1:0] w_regs_flat;

    // Next storage value and per-register set/clear decode.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_wr_val[i]    = r_regs[i];
            w_wr_hit[i]    = 1'b0;
            w_claim_hit[i] = 1'b0;
        end

        // Ascending port order: a later port overwrites an earlier one.
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w]) begin
                w_wr_hit[bus.wr_addr[w*AW +: AW]] = 1'b1;
                w_wr_val[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
            end
        end

        if (bus.claim_en) begin
            w_claim_hit[bus.claim_addr] = 1'b1;
        end

        if (ZERO_REG != 0) begin
            w_wr_hit[c_zero_reg_idx]    = 1'b0;
            w_claim_hit[c_zero_reg_idx] = 1'b0;
            w_wr_val[c_zero_reg_idx]    = r_regs[c_zero_reg_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= w_wr_val[i];
            end
            // A claim wins over a same-cycle writeback: the writeback belongs
            // to the older producer, the claim to the new one.
            r_pending <= w_claim_hit | (r_pending & ~w_wr_hit);
        end
    end

    assign bus.pending_vec = r_pending;

    for (genvar i = 0; i < NREGS; i++) begin : g_flat
        assign w_regs_flat[i*XLEN +: XLEN] = r_regs[i];
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd_port
        regfile_mp_sb_rd_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .i_addr        (bus.rd_addr[p*AW +: AW]),
            .i_regs        (w_regs_flat),
            .i_pending_vec (r_pending),
            .i_clr_vec     (w_wr_hit),
            .i_wr_en       (bus.wr_en),
            .i_wr_addr     (bus.wr_addr),
            .i_wr_data     (bus.wr_data),
            .o_data        (bus.rd_data[p*XLEN +: XLEN]),
            .o_pending     (bus.rd_pending[p])
        );
    end

endmodule : regfile_mp_sb
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Directed self-checking bench. Three register files share one
//               stimulus: default (bypass, zero register), no bypass, and no
//               zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [4:0]  claim_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_a ();
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_b ();
    regfile_mp_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus_c ();

    assign bus_a.rd_addr = rd_addr;  assign bus_b.rd_addr = rd_addr;  assign bus_c.rd_addr = rd_addr;
    assign bus_a.wr_en   = wr_en;    assign bus_b.wr_en   = wr_en;    assign bus_c.wr_en   = wr_en;
    assign bus_a.wr_addr = wr_addr;  assign bus_b.wr_addr = wr_addr;  assign bus_c.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data;  assign bus_b.wr_data = wr_data;  assign bus_c.wr_data = wr_data;
    assign bus_a.claim_en   = claim_en;   assign bus_b.claim_en   = claim_en;   assign bus_c.claim_en   = claim_en;
    assign bus_a.claim_addr = claim_addr; assign bus_b.claim_addr = claim_addr; assign bus_c.claim_addr = claim_addr;

    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1))
        u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(0))
        u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    regfile_mp_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(0), .BYPASS(1))
        u_dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd_addr = {5'd5, 5'd1};
        #1;
        check("rst_pvec_a", 64'(bus_a.pending_vec), 64'h0);
        check("rst_pvec_c", 64'(bus_c.pending_vec), 64'h0);
        check("rst_rd0_a",  64'(bus_a.rd_data[31:0]), 64'h0);
        check("rst_rd1_b",  64'(bus_b.rd_data[63:32]), 64'h0);
        check("rst_rdp_a",  64'(bus_a.rd_pending), 64'h0);

        // Write r5, claim r6, then reset with traffic that must be ignored
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hDEADBEEF;
        claim_en = 1'b1; claim_addr = 5'd6;
        tick();
        idle();
        rd_addr = {5'd6, 5'd5};
        #1;
        check("pre_rst_r5",   64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        check("pre_rst_pvec", 64'(bus_a.pending_vec), 64'h40);
        check("pre_rst_rdp1", 64'(bus_a.rd_pending[1]), 64'h1);
        reset = 1'b1;
        wr_en = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'h1111;
        claim_en = 1'b1; claim_addr = 5'd8;
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("post_rst_r5",     64'(bus_a.rd_data[31:0]), 64'h0);
        check("post_rst_pvec_a", 64'(bus_a.pending_vec), 64'h0);
        check("post_rst_pvec_c", 64'(bus_c.pending_vec), 64'h0);

        // Bypass vs. no bypass on r3
        rd_addr = {5'd0, 5'd3};
        wr_en = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h1234;
        #1;
        check("byp_same_a",  64'(bus_a.rd_data[31:0]), 64'h1234);
        check("nbyp_same_b", 64'(bus_b.rd_data[31:0]), 64'h0);
        tick();
        idle();
        #1;
        check("nbyp_next_b", 64'(bus_b.rd_data[31:0]), 64'h1234);

        // Write collision on r7: port 1 wins
        rd_addr = {5'd7, 5'd3};
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'hBBBB, 32'hAAAA};
        #1;
        check("coll_byp_a",  64'(bus_a.rd_data[63:32]), 64'hBBBB);
        check("coll_old_b",  64'(bus_b.rd_data[63:32]), 64'h0);
        tick();
        idle();
        #1;
        check("coll_next_a", 64'(bus_a.rd_data[63:32]), 64'hBBBB);
        check("coll_next_b", 64'(bus_b.rd_data[63:32]), 64'hBBBB);

        // Scoreboard lifecycle on r9
        rd_addr = {5'd0, 5'd9};
        claim_en = 1'b1; claim_addr = 5'd9;
        #1;
        check("claim_invis", 64'(bus_a.rd_pending[0]), 64'h0);
        tick();
        idle();
        #1;
        check("claim_pvec",  64'(bus_a.pending_vec), 64'h200);
        check("claim_rdp",   64'(bus_a.rd_pending[0]), 64'h1);
        wr_en = 2'b10; wr_addr[9:5] = 5'd9; wr_data[63:32] = 32'h99;
        #1;
        check("wb_rdp_byp_a",  64'(bus_a.rd_pending[0]), 64'h0);
        check("wb_rdp_nbyp_b", 64'(bus_b.rd_pending[0]), 64'h1);
        check("wb_rd_byp_a",   64'(bus_a.rd_data[31:0]), 64'h99);
        tick();
        idle();
        #1;
        check("wb_pvec_a", 64'(bus_a.pending_vec), 64'h0);

        // Claim and writeback in the same cycle: claim wins
        claim_en = 1'b1; claim_addr = 5'd9;
        tick();
        claim_en = 1'b1; claim_addr = 5'd9;
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h77;
        tick();
        idle();
        #1;
        check("cw_pvec_a", 64'(bus_a.pending_vec), 64'h200);
        check("cw_data_a", 64'(bus_a.rd_data[31:0]), 64'h77);
        wr_en = 2'b01; wr_addr[4:0] = 5'd9; wr_data[31:0] = 32'h78;
        tick();
        idle();
        #1;
        check("cw_clr_a", 64'(bus_a.pending_vec), 64'h0);

        // Zero register
        rd_addr = {5'd0, 5'd0};
        wr_en = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFFFFFF;
        claim_en = 1'b1; claim_addr = 5'd0;
        #1;
        check("z_same_a",   64'(bus_a.rd_data[31:0]), 64'h0);
        check("z_same_c",   64'(bus_c.rd_data[31:0]), 64'hFFFFFFFF);
        tick();
        idle();
        #1;
        check("z_rd_a",     64'(bus_a.rd_data[31:0]), 64'h0);
        check("z_rdp_a",    64'(bus_a.rd_pending[0]), 64'h0);
        check("z_pvec_a",   64'(bus_a.pending_vec), 64'h0);
        check("z_rd_c",     64'(bus_c.rd_data[31:0]), 64'hFFFFFFFF);
        check("z_pvec_c",   64'(bus_c.pending_vec), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp_sb
`default_nettype wire
